// File: rtl/pc_select_reg.sv
// Registered N-way word selector with previous-value copy, stall hold and
// an illegal-select trap (BOOT -> RUN <-> ERR).
module pc_select_reg #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned NUM_IN    = 3,
    parameter int unsigned SEL_W     = 2,
    parameter logic [31:0] RESET_VAL = 32'h00400030
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        select,
    input  logic                    stall,
    input  logic                    err_clr,
    output logic [WIDTH-1:0]        out,
    output logic [WIDTH-1:0]        out_prev,
    output logic                    valid,
    output logic                    sel_err,
    output logic [SEL_W-1:0]        err_sel
);

    localparam logic [WIDTH-1:0] RST_V    = WIDTH'(RESET_VAL);
    localparam logic [SEL_W:0]   NUM_IN_W = (SEL_W+1)'(NUM_IN);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_prev_q;
    logic [SEL_W-1:0] err_sel_q;
    logic             valid_q;
    logic             sel_err_q;
    logic [WIDTH-1:0] cand_d;
    logic             illegal_d;

    // Compared one bit wider so NUM_IN == 2**SEL_W simply never flags.
    always_comb begin
        illegal_d = ({1'b0, select} >= NUM_IN_W);
        cand_d    = '0;
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (select == SEL_W'(k)) begin
                cand_d = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BOOT;
            out_q      <= RST_V;
            out_prev_q <= RST_V;
            err_sel_q  <= '0;
            valid_q    <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= RUN;
                    valid_q <= 1'b1;
                end
                RUN: begin
                    if (!stall) begin
                        if (illegal_d) begin
                            err_sel_q <= select;
                            state_q   <= ERR;
                            valid_q   <= 1'b0;
                            sel_err_q <= 1'b1;
                        end else begin
                            out_prev_q <= out_q;
                            out_q      <= cand_d;
                        end
                    end
                end
                ERR: begin
                    if (err_clr) begin
                        state_q   <= RUN;
                        valid_q   <= 1'b1;
                        sel_err_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= BOOT;
                    valid_q   <= 1'b0;
                    sel_err_q <= 1'b0;
                end
            endcase
        end
    end

    assign out      = out_q;
    assign out_prev = out_prev_q;
    assign valid    = valid_q;
    assign sel_err  = sel_err_q;
    assign err_sel  = err_sel_q;

endmodule

// File: tb/tb_pc_select_reg.sv
// Directed bench for pc_select_reg: default 3-input build and a 4-input
// 16-bit build where every select is legal.
module tb_pc_select_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: WIDTH=32, NUM_IN=3
    logic        rst_a;
    logic [95:0] bus_a;
    logic [1:0]  sel_a;
    logic        stall_a, clr_a;
    logic [31:0] out_a, prev_a;
    logic        valid_a, serr_a;
    logic [1:0]  esel_a;

    pc_select_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .RESET_VAL(32'h00400030)) dut_a (
        .clk(clk), .reset(rst_a), .in_bus(bus_a), .select(sel_a), .stall(stall_a),
        .err_clr(clr_a), .out(out_a), .out_prev(prev_a), .valid(valid_a),
        .sel_err(serr_a), .err_sel(esel_a)
    );

    // Instance B: WIDTH=16, NUM_IN=4
    logic        rst_b;
    logic [63:0] bus_b;
    logic [1:0]  sel_b;
    logic        stall_b, clr_b;
    logic [15:0] out_b, prev_b;
    logic        valid_b, serr_b;
    logic [1:0]  esel_b;

    pc_select_reg #(.WIDTH(16), .NUM_IN(4), .SEL_W(2), .RESET_VAL(32'h00001234)) dut_b (
        .clk(clk), .reset(rst_b), .in_bus(bus_b), .select(sel_b), .stall(stall_b),
        .err_clr(clr_b), .out(out_b), .out_prev(prev_b), .valid(valid_b),
        .sel_err(serr_b), .err_sel(esel_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [31:0] o, input logic [31:0] p,
                         input logic v, input logic e, input logic [1:0] es);
        check({tag, ".out"}, out_a, o);
        check({tag, ".prev"}, prev_a, p);
        check({tag, ".valid"}, {31'b0, valid_a}, {31'b0, v});
        check({tag, ".sel_err"}, {31'b0, serr_a}, {31'b0, e});
        check({tag, ".err_sel"}, {30'b0, esel_a}, {30'b0, es});
    endtask

    localparam logic [31:0] RV = 32'h00400030;

    initial begin
        rst_a = 1'b1; sel_a = 2'd1; stall_a = 1'b0; clr_a = 1'b0;
        bus_a = {32'h0000000C, 32'h00000100, 32'h0000000A};
        rst_b = 1'b1; sel_b = 2'd0; stall_b = 1'b0; clr_b = 1'b0;
        bus_b = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

        step(); step();
        rst_a = 1'b0;
        chk_a("reset", RV, RV, 1'b0, 1'b0, 2'd0);
        step();
        chk_a("boot", RV, RV, 1'b1, 1'b0, 2'd0);
        step();
        chk_a("load1", 32'h100, RV, 1'b1, 1'b0, 2'd0);

        // err_clr has no effect in RUN
        bus_a[63:32] = 32'h0000000B;
        sel_a = 2'd0; clr_a = 1'b1;
        step();
        chk_a("load0", 32'hA, 32'h100, 1'b1, 1'b0, 2'd0);
        clr_a = 1'b0; sel_a = 2'd1;
        step();
        chk_a("loadB", 32'hB, 32'hA, 1'b1, 1'b0, 2'd0);

        stall_a = 1'b1; sel_a = 2'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_a("stall", 32'hB, 32'hA, 1'b1, 1'b0, 2'd0);
        end
        // illegal select under stall is not checked
        sel_a = 2'd3;
        step();
        chk_a("stall_ill", 32'hB, 32'hA, 1'b1, 1'b0, 2'd0);
        sel_a = 2'd2; stall_a = 1'b0;
        step();
        chk_a("unstall", 32'hC, 32'hB, 1'b1, 1'b0, 2'd0);

        sel_a = 2'd3;
        step();
        chk_a("illegal", 32'hC, 32'hB, 1'b0, 1'b1, 2'd3);
        for (int i = 0; i < 4; i++) begin
            stall_a = i[0];
            sel_a = 2'(i % 3);
            step();
            chk_a("err_hold", 32'hC, 32'hB, 1'b0, 1'b1, 2'd3);
        end
        stall_a = 1'b0; sel_a = 2'd0; clr_a = 1'b1;
        step();
        chk_a("err_clr", 32'hC, 32'hB, 1'b1, 1'b0, 2'd3);
        clr_a = 1'b0;
        step();
        chk_a("post_clr", 32'hA, 32'hC, 1'b1, 1'b0, 2'd3);

        sel_a = 2'd3;
        step();
        chk_a("illegal2", 32'hA, 32'hC, 1'b0, 1'b1, 2'd3);
        #2;
        rst_a = 1'b1;
        #1;
        chk_a("async_rst", RV, RV, 1'b0, 1'b0, 2'd0);
        sel_a = 2'd1;
        step();
        rst_a = 1'b0;
        chk_a("reset2", RV, RV, 1'b0, 1'b0, 2'd0);
        step();
        chk_a("boot2", RV, RV, 1'b1, 1'b0, 2'd0);
        step();
        chk_a("load_b2", 32'hB, RV, 1'b1, 1'b0, 2'd0);

        // Instance B: every select legal
        rst_b = 1'b0;
        check("B.reset", {16'b0, out_b}, 32'h1234);
        check("B.valid0", {31'b0, valid_b}, 32'd0);
        step();
        check("B.boot", {16'b0, out_b}, 32'h1234);
        for (int s = 3; s >= 0; s--) begin
            sel_b = 2'(s);
            step();
            check("B.sweep", {16'b0, out_b}, 32'h1111 * (s + 1));
            check("B.sel_err", {31'b0, serr_b}, 32'd0);
            check("B.valid", {31'b0, valid_b}, 32'd1);
        end
        check("B.prev", {16'b0, prev_b}, 32'h2222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
